// File: rtl/level_sequencer_pkg.sv
// Shared types and constants for the level sequencer: FSM state encoding,
// level/lives widths and reset values.
package level_seq_pkg;

   localparam int LEVEL_W = 4;
   localparam int LIVES_W = 2;

   localparam logic [LEVEL_W-1:0] FIRST_LEVEL = 4'd1;
   localparam logic [LIVES_W-1:0] LIVES_INIT  = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      KICK,
      WAIT_COUNT,
      ANSWER,
      MISS,
      WIN,
      LOSE
   } state_e;

   // Sizes the shared second counter so it can hold the larger of the two windows.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/level_sequencer_if.sv
// Handshake bundle between the level sequencer (master) and the surrounding
// button/answer logic and countdown block (slave).
interface level_sequencer_if;
   import level_seq_pkg::*;

   logic               Tick1Hz;
   logic               userStart;
   logic               doneCounting;
   logic               answerValid;
   logic               answerCorrect;
   logic               start;
   logic [LEVEL_W-1:0] curLevel;
   logic               roundActive;
   logic               win;
   logic               gameOver;
   logic               countErr;
   logic [LIVES_W-1:0] livesLeft;

   modport master (
      input  Tick1Hz, userStart, doneCounting, answerValid, answerCorrect,
      output start, curLevel, roundActive, win, gameOver, countErr, livesLeft
   );

   modport slave (
      output Tick1Hz, userStart, doneCounting, answerValid, answerCorrect,
      input  start, curLevel, roundActive, win, gameOver, countErr, livesLeft
   );

endinterface

// File: rtl/level_sequencer_sec_window_timer.sv
// Loadable seconds down-counter stepped by the 1 Hz enable; expire_o pulses on
// the tick that would take the count below 1.
module sec_window_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             run_i,
   input  logic             tick_i,
   output logic             expire_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (run_i && tick_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = run_i && tick_i && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/level_sequencer.sv
// Game round sequencer: kicks the countdown block, waits for it, then times the
// player's answer window. Optional lives support under `LEVEL_SEQ_LIVES_EN.
module level_sequencer
   import level_seq_pkg::*;
#(
   parameter int MAX_LEVEL     = 9,
   parameter int ANSWER_SECS   = 5,
   parameter int COUNT_TIMEOUT = 10
) (
   input  logic              Clk100M,
   input  logic              Reset,
   level_sequencer_if.master seq_if
);

   localparam int CNT_W = $clog2(max_int(ANSWER_SECS, COUNT_TIMEOUT) + 1);

   state_e             state_q, state_d;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic               start_q, start_d;
   logic               round_q, round_d;
   logic               win_q, win_d;
   logic               over_q, over_d;
   logic               cerr_q, cerr_d;

   logic               tmr_clr, tmr_load, tmr_run, tmr_expire;
   logic [CNT_W-1:0]   tmr_val;
   logic               at_max;

   assign at_max = (level_q == LEVEL_W'(MAX_LEVEL));

   // One counter serves both the countdown watchdog and the answer window.
   always_comb begin
      tmr_clr  = (state_q == IDLE) || (state_q == WIN) || (state_q == LOSE);
      tmr_load = (state_q == KICK) || ((state_q == WAIT_COUNT) && seq_if.doneCounting);
      tmr_val  = (state_q == KICK) ? CNT_W'(COUNT_TIMEOUT) : CNT_W'(ANSWER_SECS);
      tmr_run  = (state_q == WAIT_COUNT) || (state_q == ANSWER);
   end

   sec_window_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk        (Clk100M),
      .rst        (Reset),
      .clr_i      (tmr_clr),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .run_i      (tmr_run),
      .tick_i     (seq_if.Tick1Hz),
      .expire_o   (tmr_expire)
   );

`ifdef LEVEL_SEQ_LIVES_EN
   logic [LIVES_W-1:0] lives_q, lives_d;
`endif

   always_ff @(posedge Clk100M) begin
      if (Reset) begin
         state_q <= IDLE;
         level_q <= FIRST_LEVEL;
         start_q <= 1'b0;
         round_q <= 1'b0;
         win_q   <= 1'b0;
         over_q  <= 1'b0;
         cerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         start_q <= start_d;
         round_q <= round_d;
         win_q   <= win_d;
         over_q  <= over_d;
         cerr_q  <= cerr_d;
      end
   end

`ifdef LEVEL_SEQ_LIVES_EN
   always_ff @(posedge Clk100M) begin
      if (Reset) begin
         lives_q <= LIVES_INIT;
      end else begin
         lives_q <= lives_d;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (seq_if.userStart) state_d = KICK;
         end
         KICK: begin
            state_d = WAIT_COUNT;
         end
         WAIT_COUNT: begin
            if (seq_if.doneCounting) begin
               state_d = ANSWER;
            end else if (tmr_expire) begin
               state_d = LOSE;
            end
         end
         ANSWER: begin
            // A submitted answer takes priority over a window expiring on the same edge.
            if (seq_if.answerValid) begin
               if (!seq_if.answerCorrect) begin
                  state_d = MISS;
               end else if (at_max) begin
                  state_d = WIN;
               end else begin
                  state_d = KICK;
               end
            end else if (tmr_expire) begin
               state_d = MISS;
            end
         end
         MISS: begin
`ifdef LEVEL_SEQ_LIVES_EN
            state_d = (lives_q > LIVES_W'(1)) ? KICK : LOSE;
`else
            state_d = LOSE;
`endif
         end
         WIN, LOSE: begin
            if (seq_if.userStart) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      start_d = (state_d == KICK);
      round_d = (state_d == ANSWER);
      win_d   = (state_d == WIN);
      over_d  = (state_d == LOSE);
      level_d = level_q;
      cerr_d  = cerr_q;
      if ((state_q == ANSWER) && seq_if.answerValid && seq_if.answerCorrect && !at_max) begin
         level_d = level_q + LEVEL_W'(1);
      end
      if ((state_q == WAIT_COUNT) && !seq_if.doneCounting && tmr_expire) begin
         cerr_d = 1'b1;
      end
      if (((state_q == WIN) || (state_q == LOSE)) && seq_if.userStart) begin
         level_d = FIRST_LEVEL;
         cerr_d  = 1'b0;
      end
   end

`ifdef LEVEL_SEQ_LIVES_EN
   always_comb begin
      lives_d = lives_q;
      if (state_q == MISS) begin
         lives_d = lives_q - LIVES_W'(1);
      end else if (((state_q == WIN) || (state_q == LOSE)) && seq_if.userStart) begin
         lives_d = LIVES_INIT;
      end
   end

   assign seq_if.livesLeft = lives_q;
`else
   assign seq_if.livesLeft = '0;
`endif

   assign seq_if.start       = start_q;
   assign seq_if.curLevel    = level_q;
   assign seq_if.roundActive = round_q;
   assign seq_if.win         = win_q;
   assign seq_if.gameOver    = over_q;
   assign seq_if.countErr    = cerr_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Bench for level_sequencer: expected start levels are queued as stimulus is
// driven and checked against every observed start pulse.
module tb_level_sequencer;
   import level_seq_pkg::*;

`ifdef LEVEL_SEQ_LIVES_EN
   localparam logic [1:0] LIVES_EXP = 2'd3;
`else
   localparam logic [1:0] LIVES_EXP = 2'd0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   level_sequencer_if bus();

   level_sequencer #(
      .MAX_LEVEL     (9),
      .ANSWER_SECS   (5),
      .COUNT_TIMEOUT (10)
   ) dut (
      .Clk100M (clk),
      .Reset   (rst),
      .seq_if  (bus.master)
   );

   int n_chk = 0;
   int n_bad = 0;
   logic [3:0] sb_q[$];
   logic prev_start = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // Every start pulse must be isolated and carry the level queued for it.
   always @(negedge clk) begin
      if (bus.start === 1'b1) begin
         chk("start_gap", 32'(prev_start), 32'd0);
         chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) chk("start_level", 32'(bus.curLevel), 32'(sb_q.pop_front()));
      end
      prev_start <= bus.start;
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_user();
      bus.userStart = 1'b1;
      step();
      bus.userStart = 1'b0;
   endtask

   task automatic pulse_done();
      bus.doneCounting = 1'b1;
      step();
      bus.doneCounting = 1'b0;
   endtask

   task automatic answer(input logic ok);
      bus.answerValid   = 1'b1;
      bus.answerCorrect = ok;
      step();
      bus.answerValid   = 1'b0;
      bus.answerCorrect = 1'b0;
   endtask

   task automatic tick_n(input int n);
      repeat (n) begin
         bus.Tick1Hz = 1'b1;
         step();
         bus.Tick1Hz = 1'b0;
         step();
      end
   endtask

   task automatic wait_start();
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (bus.start === 1'b1) begin
            seen = 1'b1;
            break;
         end
         step();
      end
      chk("start_seen", 32'(seen), 32'd1);
      step();
      chk("start_width", 32'(bus.start), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(2);
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got 1 want 0");
      $fatal(1, "bench timeout");
   end

   initial begin
      bus.Tick1Hz       = 1'b0;
      bus.userStart     = 1'b0;
      bus.doneCounting  = 1'b0;
      bus.answerValid   = 1'b0;
      bus.answerCorrect = 1'b0;
      rst = 1'b1;
      step(3);
      rst = 1'b0;
      step();

      chk("rst_level", 32'(bus.curLevel), 32'd1);
      chk("rst_start", 32'(bus.start), 32'd0);
      chk("rst_round", 32'(bus.roundActive), 32'd0);
      chk("rst_win", 32'(bus.win), 32'd0);
      chk("rst_over", 32'(bus.gameOver), 32'd0);
      chk("rst_cerr", 32'(bus.countErr), 32'd0);
      chk("rst_lives", 32'(bus.livesLeft), 32'(LIVES_EXP));

      // First round, countdown finishing after 7 seconds.
      sb_q.push_back(4'd1);
      pulse_user();
      wait_start();
      tick_n(7);
      pulse_done();
      chk("t1_round", 32'(bus.roundActive), 32'd1);
      sb_q.push_back(4'd2);
      answer(1'b1);
      chk("t1_level", 32'(bus.curLevel), 32'd2);
      wait_start();

      // Climb to the top level and win.
      for (int lvl = 2; lvl <= 9; lvl++) begin
         tick_n(1);
         pulse_done();
         chk("t2_round", 32'(bus.roundActive), 32'd1);
         if (lvl < 9) sb_q.push_back(4'(lvl + 1));
         answer(1'b1);
         if (lvl < 9) wait_start();
      end
      chk("t2_win", 32'(bus.win), 32'd1);
      chk("t2_level", 32'(bus.curLevel), 32'd9);
      chk("t2_round_off", 32'(bus.roundActive), 32'd0);
      step(20);
      chk("t2_win_hold", 32'(bus.win), 32'd1);
      pulse_user();
      chk("t2_idle_win", 32'(bus.win), 32'd0);
      chk("t2_idle_level", 32'(bus.curLevel), 32'd1);

      // Answer window expires without an answer.
      sb_q.push_back(4'd1);
      pulse_user();
      wait_start();
      pulse_done();
      tick_n(4);
      chk("t3_open", 32'(bus.roundActive), 32'd1);
`ifdef LEVEL_SEQ_LIVES_EN
      sb_q.push_back(4'd1);
      tick_n(1);
      chk("t3_lives", 32'(bus.livesLeft), 32'd2);
      chk("t3_over", 32'(bus.gameOver), 32'd0);
      wait_start();
      do_reset();
`else
      tick_n(1);
      chk("t3_over", 32'(bus.gameOver), 32'd1);
      chk("t3_round", 32'(bus.roundActive), 32'd0);
      pulse_user();
      chk("t3_restart", 32'(bus.gameOver), 32'd0);
`endif

      // Spurious doneCounting in IDLE, then a countdown that never finishes.
      pulse_done();
      chk("t4_spur_start", 32'(bus.start), 32'd0);
      chk("t4_spur_round", 32'(bus.roundActive), 32'd0);
      sb_q.push_back(4'd1);
      pulse_user();
      wait_start();
      tick_n(9);
      chk("t4_cerr_early", 32'(bus.countErr), 32'd0);
      chk("t4_over_early", 32'(bus.gameOver), 32'd0);
      tick_n(1);
      chk("t4_cerr", 32'(bus.countErr), 32'd1);
      chk("t4_over", 32'(bus.gameOver), 32'd1);
      pulse_user();
      chk("t4_cerr_clr", 32'(bus.countErr), 32'd0);
      chk("t4_over_clr", 32'(bus.gameOver), 32'd0);
      chk("t4_level", 32'(bus.curLevel), 32'd1);

      // Correct answer on the same edge as the expiring tick.
      sb_q.push_back(4'd1);
      pulse_user();
      wait_start();
      pulse_done();
      tick_n(4);
      sb_q.push_back(4'd2);
      bus.Tick1Hz       = 1'b1;
      bus.answerValid   = 1'b1;
      bus.answerCorrect = 1'b1;
      step();
      bus.Tick1Hz       = 1'b0;
      bus.answerValid   = 1'b0;
      bus.answerCorrect = 1'b0;
      chk("t5_level", 32'(bus.curLevel), 32'd2);
      chk("t5_over", 32'(bus.gameOver), 32'd0);
      chk("t5_round", 32'(bus.roundActive), 32'd0);
      wait_start();

      // Reach level 4 and reset in the middle of its answer window.
      pulse_done();
      sb_q.push_back(4'd3);
      answer(1'b1);
      wait_start();
      pulse_done();
      sb_q.push_back(4'd4);
      answer(1'b1);
      wait_start();
      pulse_done();
      chk("t6_level4", 32'(bus.curLevel), 32'd4);
      chk("t6_round_on", 32'(bus.roundActive), 32'd1);
      rst               = 1'b1;
      bus.answerValid   = 1'b1;
      bus.answerCorrect = 1'b1;
      step();
      rst               = 1'b0;
      bus.answerValid   = 1'b0;
      bus.answerCorrect = 1'b0;
      chk("t6_level", 32'(bus.curLevel), 32'd1);
      chk("t6_round", 32'(bus.roundActive), 32'd0);
      chk("t6_cerr", 32'(bus.countErr), 32'd0);
      chk("t6_start", 32'(bus.start), 32'd0);
      chk("t6_lives", 32'(bus.livesLeft), 32'(LIVES_EXP));
      step(5);
      chk("t6_idle_start", 32'(bus.start), 32'd0);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
